// File: rtl/rmt_parser_pkg.sv
// rtl/rmt_parser_pkg.sv - shared parse-action field positions, size codes and container type encodings
package rmt_parser_pkg;

    // {a[5:4], a[0]} size codes; a[0] is the action-valid bit
    localparam logic [2:0] SZ_2B = 3'b011;
    localparam logic [2:0] SZ_4B = 3'b101;
    localparam logic [2:0] SZ_6B = 3'b111;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_2B   = 2'b01;
    localparam logic [1:0] TYPE_4B   = 2'b10;
    localparam logic [1:0] TYPE_6B   = 2'b11;

    localparam int ACT_VLD    = 0;
    localparam int ACT_SEQ_LO = 1;
    localparam int ACT_SEQ_HI = 3;
    localparam int ACT_SZ_LO  = 4;
    localparam int ACT_SZ_HI  = 5;
    localparam int ACT_OFF_LO = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sub_parser_mc_if.sv
// rtl/sub_parser_mc_if.sv - packet input and beat output handshake bundle of the multi-lane sub-parser
interface sub_parser_mc_if #(
    parameter int PKTS_HDR_LEN  = 1024,
    parameter int PARSE_ACT_LEN = 16,
    parameter int VAL_OUT_LEN   = 48,
    parameter int NUM_ACTS      = 8,
    parameter int LANES         = 2
);
    logic                              s_valid;
    logic                              s_ready;
    logic [PKTS_HDR_LEN-1:0]           pkts_hdr;
    logic [NUM_ACTS*PARSE_ACT_LEN-1:0] parse_acts;
    logic                              m_valid;
    logic                              m_ready;
    logic                              m_last;
    logic [LANES-1:0]                  val_out_valid;
    logic [LANES*VAL_OUT_LEN-1:0]      val_out;
    logic [LANES*2-1:0]                val_out_type;
    logic [LANES*3-1:0]                val_out_seq;
    logic [LANES-1:0]                  val_out_err;

    modport slave (
        input  s_valid, pkts_hdr, parse_acts, m_ready,
        output s_ready, m_valid, m_last, val_out_valid, val_out,
               val_out_type, val_out_seq, val_out_err
    );

    modport master (
        output s_valid, pkts_hdr, parse_acts, m_ready,
        input  s_ready, m_valid, m_last, val_out_valid, val_out,
               val_out_type, val_out_seq, val_out_err
    );
endinterface

// File: rtl/sub_parser_lane.sv
// rtl/sub_parser_lane.sv - combinational decode and extraction of one parse action against the header
module sub_parser_lane
    import rmt_parser_pkg::*;
#(
    parameter int PKTS_HDR_LEN  = 1024,
    parameter int PARSE_ACT_LEN = 16,
    parameter int VAL_OUT_LEN   = 48,
    parameter int OFF_W         = 7
) (
    input  logic [PKTS_HDR_LEN-1:0]  hdr,
    input  logic [PARSE_ACT_LEN-1:0] act,
    output logic                     valid,
    output logic [VAL_OUT_LEN-1:0]   val,
    output logic [1:0]               val_type,
    output logic [2:0]               seq,
    output logic                     err
);
    localparam int              SH_W      = $clog2(PKTS_HDR_LEN) + 1;
    localparam logic [OFF_W:0]  HDR_BYTES = (OFF_W+1)'(PKTS_HDR_LEN / 8);

    logic [2:0]             code;
    logic [OFF_W-1:0]       off;
    logic [SH_W-1:0]        bit_off;
    logic [OFF_W:0]         end_byte;
    logic [3:0]             nbytes;
    logic [1:0]             typ;
    logic [VAL_OUT_LEN-1:0] mask;
    logic                   known;
    logic                   oob;

    // Action bits above the offset field carry no meaning for extraction
    if (PARSE_ACT_LEN > ACT_OFF_LO + OFF_W) begin : g_spare
        logic unused_act_bits;
        assign unused_act_bits = ^act[PARSE_ACT_LEN-1:ACT_OFF_LO+OFF_W];
    end

    // Decode size, check the byte range and pull the container out of the header
    always_comb begin
        code     = {act[ACT_SZ_HI:ACT_SZ_LO], act[ACT_VLD]};
        off      = act[ACT_OFF_LO +: OFF_W];
        bit_off  = SH_W'(off) << 3;
        nbytes   = 4'd0;
        typ      = TYPE_NONE;
        case (code)
            SZ_2B: begin nbytes = 4'd2; typ = TYPE_2B; end
            SZ_4B: begin nbytes = 4'd4; typ = TYPE_4B; end
            SZ_6B: begin nbytes = 4'd6; typ = TYPE_6B; end
            default: begin nbytes = 4'd0; typ = TYPE_NONE; end
        endcase
        known    = (nbytes != 4'd0);
        end_byte = (OFF_W+1)'(off) + (OFF_W+1)'(nbytes);
        oob      = known && (end_byte > HDR_BYTES);
        mask     = ~({VAL_OUT_LEN{1'b1}} << {nbytes, 3'b000});
        valid    = known && !oob;
        err      = oob;
        val      = valid ? (VAL_OUT_LEN'(hdr >> bit_off) & mask) : '0;
        val_type = valid ? typ : TYPE_NONE;
        seq      = valid ? act[ACT_SEQ_HI:ACT_SEQ_LO] : 3'd0;
    end
endmodule

// File: rtl/sub_parser_mc.sv
// rtl/sub_parser_mc.sv - multi-lane, multi-beat parse-action extractor with backpressured beat register
module sub_parser_mc
    import rmt_parser_pkg::*;
#(
    parameter int PKTS_HDR_LEN  = 1024,
    parameter int PARSE_ACT_LEN = 16,
    parameter int VAL_OUT_LEN   = 48,
    parameter int NUM_ACTS      = 8,
    parameter int LANES         = 2,
    parameter int OFF_W         = 7
) (
    input  logic           clk,
    input  logic           aresetn,
    sub_parser_mc_if.slave bus
);
    localparam int BEATS  = NUM_ACTS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                            state;
    logic [BEAT_W-1:0]                 beat;
    logic [PKTS_HDR_LEN-1:0]           hdr_q;
    logic [NUM_ACTS*PARSE_ACT_LEN-1:0] acts_q;

    logic                              m_valid_q;
    logic                              m_last_q;
    logic [LANES-1:0]                  vld_q;
    logic [LANES*VAL_OUT_LEN-1:0]      val_q;
    logic [LANES*2-1:0]                typ_q;
    logic [LANES*3-1:0]                seq_q;
    logic [LANES-1:0]                  err_q;

    logic [PARSE_ACT_LEN-1:0]          lane_act [LANES];
    logic [LANES-1:0]                  ln_valid;
    logic [LANES*VAL_OUT_LEN-1:0]      ln_val;
    logic [LANES*2-1:0]                ln_typ;
    logic [LANES*3-1:0]                ln_seq;
    logic [LANES-1:0]                  ln_err;
    logic                              load;
    logic                              last_beat;

    // Route the current beat's slice of the latched action vector to the lanes
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_act[l] = acts_q[(int'(beat) * LANES + l) * PARSE_ACT_LEN +: PARSE_ACT_LEN];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sub_parser_lane #(
            .PKTS_HDR_LEN  (PKTS_HDR_LEN),
            .PARSE_ACT_LEN (PARSE_ACT_LEN),
            .VAL_OUT_LEN   (VAL_OUT_LEN),
            .OFF_W         (OFF_W)
        ) u_lane (
            .hdr      (hdr_q),
            .act      (lane_act[l]),
            .valid    (ln_valid[l]),
            .val      (ln_val[l*VAL_OUT_LEN +: VAL_OUT_LEN]),
            .val_type (ln_typ[l*2 +: 2]),
            .seq      (ln_seq[l*3 +: 3]),
            .err      (ln_err[l])
        );
    end

    assign load      = (state == ST_RUN) && (!m_valid_q || bus.m_ready);
    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    // Packet FSM: latch in IDLE, emit one beat per free output slot in RUN, wait for final handshake in DRAIN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            beat      <= '0;
            hdr_q     <= '0;
            acts_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            vld_q     <= '0;
            val_q     <= '0;
            typ_q     <= '0;
            seq_q     <= '0;
            err_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.s_valid) begin
                        hdr_q  <= bus.pkts_hdr;
                        acts_q <= bus.parse_acts;
                        beat   <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        m_valid_q <= 1'b1;
                        m_last_q  <= last_beat;
                        vld_q     <= ln_valid;
                        val_q     <= ln_val;
                        typ_q     <= ln_typ;
                        seq_q     <= ln_seq;
                        err_q     <= ln_err;
                        beat      <= beat + 1'b1;
                        if (last_beat) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_valid_q && bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is held low for the whole time reset is asserted
    assign bus.s_ready       = (state == ST_IDLE) && aresetn;
    assign bus.m_valid       = m_valid_q;
    assign bus.m_last        = m_last_q;
    assign bus.val_out_valid = vld_q;
    assign bus.val_out       = val_q;
    assign bus.val_out_type  = typ_q;
    assign bus.val_out_seq   = seq_q;
    assign bus.val_out_err   = err_q;
endmodule

// File: tb/tb_sub_parser_mc.sv
// tb/tb_sub_parser_mc.sv - scoreboard bench for sub_parser_mc with directed packets
module tb_sub_parser_mc;

    typedef struct packed {
        logic        last;
        logic [1:0]  vv;
        logic [95:0] val;
        logic [3:0]  typ;
        logic [5:0]  seq;
        logic [1:0]  err;
    } beat_t;

    logic clk;
    logic aresetn;
    int   checks = 0;
    int   errors = 0;
    int   last_cnt = 0;
    beat_t sb[$];

    logic [1023:0] hdr_a, hdr_b;
    logic [127:0]  acts_a, acts_b;
    beat_t         exp_a [4];
    beat_t         exp_b [4];

    sub_parser_mc_if bus ();

    sub_parser_mc dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] act(int off, int sz, int seq, int vld);
        logic [15:0] a;
        a = 16'((off << 6) | (sz << 4) | (seq << 1) | vld);
        return a;
    endfunction

    function automatic beat_t mk(logic last,
                                 logic v0, logic [47:0] x0, logic [1:0] t0, logic [2:0] s0, logic e0,
                                 logic v1, logic [47:0] x1, logic [1:0] t1, logic [2:0] s1, logic e1);
        beat_t b;
        b.last = last;
        b.vv   = {v1, v0};
        b.val  = {x1, x0};
        b.typ  = {t1, t0};
        b.seq  = {s1, s0};
        b.err  = {e1, e0};
        return b;
    endfunction

    function automatic beat_t got_beat();
        beat_t b;
        b.last = bus.m_last;
        b.vv   = bus.val_out_valid;
        b.val  = bus.val_out;
        b.typ  = bus.val_out_type;
        b.seq  = bus.val_out_seq;
        b.err  = bus.val_out_err;
        return b;
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: every beat accepted downstream is compared with the oldest expectation
    always @(negedge clk) begin
        if (aresetn && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat got=%h", got_beat());
            end else begin
                chk("beat", 128'(got_beat()), 128'(sb.pop_front()));
            end
            if (bus.m_last) last_cnt++;
        end
    end

    task automatic send(input logic [1023:0] h, input logic [127:0] a);
        bit done = 0;
        bus.pkts_hdr   = h;
        bus.parse_acts = a;
        bus.s_valid    = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        bus.s_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=0 exp=1");
        end
    endtask

    task automatic wait_last(input int target);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            if (last_cnt >= target) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL last_timeout got=%0d exp=%0d", last_cnt, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 128; i++) begin
            hdr_a[i*8 +: 8] = 8'(i);
            hdr_b[i*8 +: 8] = 8'(255 - i);
        end
        acts_a = {act(126,1,4,1), act(3,0,6,1), act(40,2,7,1), act(5,1,0,0),
                  act(122,3,3,1), act(125,2,2,1), act(0,3,5,1), act(12,1,1,1)};
        acts_b = {act(123,3,7,1), act(8,2,3,1), 16'h0000, act(0,3,1,1),
                  act(64,3,2,1), act(127,1,1,1), act(100,1,6,1), act(0,2,0,1)};
        exp_a[0] = mk(0, 1, 48'h0D0C, 2'b01, 3'd1, 0,  1, 48'h050403020100, 2'b11, 3'd5, 0);
        exp_a[1] = mk(0, 0, 48'h0, 2'b00, 3'd0, 1,     1, 48'h7F7E7D7C7B7A, 2'b11, 3'd3, 0);
        exp_a[2] = mk(0, 0, 48'h0, 2'b00, 3'd0, 0,     1, 48'h2B2A2928, 2'b10, 3'd7, 0);
        exp_a[3] = mk(1, 0, 48'h0, 2'b00, 3'd0, 0,     1, 48'h7F7E, 2'b01, 3'd4, 0);
        exp_b[0] = mk(0, 1, 48'hFCFDFEFF, 2'b10, 3'd0, 0, 1, 48'h9A9B, 2'b01, 3'd6, 0);
        exp_b[1] = mk(0, 0, 48'h0, 2'b00, 3'd0, 1,     1, 48'hBABBBCBDBEBF, 2'b11, 3'd2, 0);
        exp_b[2] = mk(0, 1, 48'hFAFBFCFDFEFF, 2'b11, 3'd1, 0, 0, 48'h0, 2'b00, 3'd0, 0);
        exp_b[3] = mk(1, 1, 48'hF4F5F6F7, 2'b10, 3'd3, 0, 0, 48'h0, 2'b00, 3'd0, 1);

        aresetn        = 1'b0;
        bus.s_valid    = 1'b0;
        bus.pkts_hdr   = '0;
        bus.parse_acts = '0;
        bus.m_ready    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_s_ready", 128'(bus.s_ready), 128'(0));
        chk("reset_outputs", 128'({bus.m_valid, got_beat()}), 128'(0));
        #2 aresetn = 1'b1;
        #1;
        chk("post_reset_s_ready", 128'(bus.s_ready), 128'(1));

        // Packet A, no backpressure
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(exp_a[i]);
        send(hdr_a, acts_a);
        chk("no_beat_at_accept", 128'(bus.m_valid), 128'(0));
        @(posedge clk);
        #1;
        chk("beat0_latency", 128'(bus.m_valid), 128'(1));
        wait_last(1);
        ok = 0;
        for (int i = 0; i < 2 && !ok; i++) begin
            #1;
            if (bus.s_ready) ok = 1;
            else @(posedge clk);
        end
        chk("s_ready_return", 128'(ok), 128'(1));

        // Packet A again with a 5-cycle stall on beat 1 and a stray s_valid
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(exp_a[i]);
        send(hdr_a, acts_a);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready    = 1'b0;
        bus.pkts_hdr   = hdr_b;
        bus.parse_acts = acts_b;
        bus.s_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_beat1", 128'(got_beat()), 128'(exp_a[1]));
            chk("stall_ctrl", 128'({bus.m_valid, bus.s_ready}), 128'(2'b10));
            if (i == 1) bus.s_valid = 1'b0;
        end
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        wait_last(2);

        // Packet B interrupted by reset while beat 2 is presented
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) sb.push_back(exp_b[i]);
        send(hdr_b, acts_b);
        repeat (3) @(posedge clk);
        #2 aresetn = 1'b0;
        #1;
        chk("async_reset_outputs", 128'({bus.m_valid, got_beat()}), 128'(0));
        chk("async_reset_s_ready", 128'(bus.s_ready), 128'(0));
        sb.delete();
        @(posedge clk);
        #3 aresetn = 1'b1;
        #1;
        chk("rerun_s_ready", 128'(bus.s_ready), 128'(1));

        // Fresh packet B after reset
        for (int i = 0; i < 4; i++) sb.push_back(exp_b[i]);
        send(hdr_b, acts_b);
        wait_last(3);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        chk("idle_after_drain", 128'({bus.s_ready, bus.m_valid}), 128'(2'b10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sub_parser_mc.md
Name: sub_parser_mc

Overview:
- Multi-lane, multi-beat successor to the single-action sub-parser in the RMT parser stage.
- Accepts one packet header plus a vector of NUM_ACTS parse actions per packet with a valid/ready handshake.
- Extracts LANES containers per cycle over NUM_ACTS/LANES beats and presents each beat on a backpressured output register.
- Adds per-lane out-of-bounds detection and a last-beat marker, so the PHV builder can consume containers at its own rate.

Parameters:
- PKTS_HDR_LEN, 1024, header width in bits (multiple of 8).
- PARSE_ACT_LEN, 16, width of one parse action.
- VAL_OUT_LEN, 48, max container width in bits (must be ≥48).
- NUM_ACTS, 8, parse actions per packet.
- LANES, 2, containers extracted per beat; NUM_ACTS % LANES == 0 is required.
- OFF_W, 7, byte-offset field width; offset = act[6+OFF_W-1:6].

Ports:
- clk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_valid, in, 1, header+actions valid.
- s_ready, out, 1, block can accept a packet.
- pkts_hdr, in, PKTS_HDR_LEN, packet header; byte 0 at bits [7:0].
- parse_acts, in, NUM_ACTS*PARSE_ACT_LEN, action i at [i*PARSE_ACT_LEN +: PARSE_ACT_LEN].
- m_valid, out, 1, output beat valid.
- m_ready, in, 1, downstream accepts beat.
- m_last, out, 1, final beat of packet.
- val_out_valid, out, LANES, per-lane container valid.
- val_out, out, LANES*VAL_OUT_LEN, per-lane extracted value, zero-extended.
- val_out_type, out, LANES*2, 01=2B, 10=4B, 11=6B, 00=none.
- val_out_seq, out, LANES*3, container index = act[3:1].
- val_out_err, out, LANES, lane action was in range-violation.

Behaviour:
- Reset (async, aresetn=0): state=IDLE, s_ready=0 while in reset, 1 in the first cycle after deassertion. All outputs, beat counter and latched header/actions are cleared to 0. A reset mid-packet discards the packet; nothing resumes.
- States:
  - IDLE: s_ready=1. On s_valid&s_ready, latch pkts_hdr and parse_acts, set beat=0, go to RUN.
  - RUN: s_ready=0. The output register loads when (!m_valid || m_ready). Each load presents actions [beat*LANES +: LANES] and increments beat. The load of beat BEATS-1 (BEATS=NUM_ACTS/LANES) sets m_last=1 and moves to DRAIN.
  - DRAIN: s_ready=0. When m_ready is seen with m_valid, clear m_valid and go to IDLE.
- Output register:
  - m_valid stays high and all data is held stable until m_valid&m_ready.
  - m_valid drops after a handshake unless a new beat loads in the same cycle.
- Latency, no backpressure:
  - Accept on edge E0; beat k registered on edge E(k+1).
  - The last beat is consumed on E(BEATS+1)+; the next packet is accepted no earlier than 1 cycle after that.
  - Minimum packet period is BEATS+2 cycles.
- Lane decode (action a), keyed on {a[5:4],a[0]}:
  - 011 gives 2B, 101 gives 4B, 111 gives 6B.
  - Any other code: lane valid=0, type=00, val=0, seq=0, err=0.
- Extraction: val_out lane = hdr[off*8 +: size*8], zero-extended to VAL_OUT_LEN; seq = a[3:1].
- Bounds: if off + size_bytes > PKTS_HDR_LEN/8, the lane gives valid=0, val=0, type=00, seq=0, err=1. The other lanes are unaffected.
- Width rules:
  - off*8 is computed at width clog2(PKTS_HDR_LEN)+1 to avoid truncation.
  - The bounds compare uses OFF_W+1 bits.
- Boundaries:
  - s_valid is ignored outside IDLE.
  - m_ready held low indefinitely stalls the block with no data loss.
  - When BEATS=1, the first beat is also the last.

Decomposition:
- Shared package rmt_parser_pkg holds:
  - size-code constants (SZ_2B=3'b011, SZ_4B=3'b101, SZ_6B=3'b111);
  - type encodings 01/10/11;
  - action bit-field position localparams (VLD=0, SEQ=3:1, SZ=5:4, OFF=6+).
- One sub-module: sub_parser_lane, combinational. It takes one action plus the header and returns valid/val/type/seq/err, and is instantiated LANES times under generate.
- The FSM, beat counter and output register stay in the top.

Test Plan:
- Default params: hdr byte i = i; act0 = off 12, 2B, seq 1; act1 = off 0, 6B, seq 5; m_ready=1 → beat0 gives lane0 val=0x0D0C type 01 seq 1, lane1 val=0x050403020100 type 11 seq 5. m_last=1 on beat 3 only, and s_ready returns within 2 cycles.
- act2 = off 125, 4B → lane0 of beat1 gives err=1, valid=0, val=0. act3 = off 122, 6B (exact fit, ends byte 127) gives valid=1, err=0.
- Action with a[0]=0, or code 001 → lane valid=0, type=00, err=0. The other lane extracts normally.
- Hold m_ready=0 for 5 cycles on beat 1 → outputs stable, beat counter frozen, s_ready=0. Release → beats 1..3 delivered in order, no loss.
- Pulse s_valid with a different header during RUN → ignored; outputs still carry the first header's values.
- Drop aresetn asynchronously mid-beat 2 → all outputs 0 immediately. After release s_ready=1 and a new packet extracts correctly from beat 0.
